// File: rtl/sram_w_loader_pkg.sv
// Shared constants and FSM state type for the weight SRAM loader and its SRAM-side consumer.
package sram_w_pkg;

  localparam int IN_W             = 32;
  localparam int WEIGHT_W         = 16;
  localparam int LINE_W           = 512;
  localparam int ADDR_W           = 6;
  localparam int BEATS            = LINE_W / IN_W;
  localparam int WEIGHTS_PER_BEAT = IN_W / WEIGHT_W;
  localparam int SRAM_DEPTH       = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_w_loader_line_packer.sv
// Line assembler: beat counter, slot-addressed line register and line-full flag.
module line_packer
  import sram_w_pkg::*;
#(
  parameter int IN_W   = sram_w_pkg::IN_W,
  parameter int LINE_W = sram_w_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_en,
  input  logic [IN_W-1:0]   beat_data,
  input  logic              consume,
  output logic              last_beat,
  output logic              full,
  output logic [LINE_W-1:0] line
);

  localparam int N_BEATS = LINE_W / IN_W;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BEATS - 1);

  logic [CNT_W-1:0]  beat_cnt_r;
  logic              full_r;
  logic [LINE_W-1:0] line_r;

  assign last_beat = (beat_cnt_r == CNT_LAST);
  assign full      = full_r;
  assign line      = line_r;

  // Store each accepted beat into its slot; full marks a completed line until the write consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= {CNT_W{1'b0}};
      full_r     <= 1'b0;
      line_r     <= {LINE_W{1'b0}};
    end else if (beat_en) begin
      line_r[int'(beat_cnt_r) * IN_W +: IN_W] <= beat_data;
      if (beat_cnt_r == CNT_LAST) begin
        beat_cnt_r <= {CNT_W{1'b0}};
        full_r     <= 1'b1;
      end else begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1'b1);
        full_r     <= 1'b0;
      end
    end else if (consume) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

endmodule

// File: rtl/sram_w_loader.sv
// Weight SRAM loader: packs 2-weight beats into 512-bit lines and writes consecutive rows.
// Optional SRAM_W_LOADER_CHECKSUM_EN adds a modulo-2^16 running sum of accepted weights.
module sram_w_loader
  import sram_w_pkg::*;
#(
  parameter int IN_W     = sram_w_pkg::IN_W,
  parameter int WEIGHT_W = sram_w_pkg::WEIGHT_W,
  parameter int LINE_W   = sram_w_pkg::LINE_W,
  parameter int ADDR_W   = sram_w_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_rows,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic              sram_csb,
  output logic              sram_wsb,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [LINE_W-1:0] sram_wdata,
  output logic              busy,
  output logic              done
`ifdef SRAM_W_LOADER_CHECKSUM_EN
  ,
  output logic [WEIGHT_W-1:0] checksum
`endif
);

  state_e            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   rows_left_r;
  logic              in_ready_r;
  logic              csb_r;
  logic              wsb_r;
  logic              busy_r;
  logic              done_r;

  logic              hs_s;
  logic              last_beat_s;
  logic              full_s;
  logic              consume_s;
  logic [LINE_W-1:0] line_s;

  // A completed but unwritten line blocks further beats even if in_ready were ever high.
  assign hs_s      = in_valid && in_ready_r && !full_s;
  assign consume_s = (state_r == WRITE);

  assign in_ready   = in_ready_r;
  assign sram_csb   = csb_r;
  assign sram_wsb   = wsb_r;
  assign sram_waddr = addr_r;
  assign sram_wdata = line_s;
  assign busy       = busy_r;
  assign done       = done_r;

  line_packer #(
    .IN_W   (IN_W),
    .LINE_W (LINE_W)
  ) u_line_packer (
    .clk       (clk),
    .rst       (rst),
    .beat_en   (hs_s),
    .beat_data (in_data),
    .consume   (consume_s),
    .last_beat (last_beat_s),
    .full      (full_s),
    .line      (line_s)
  );

  // Load sequencer: all handshake and SRAM strobes are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      rows_left_r <= {(ADDR_W+1){1'b0}};
      in_ready_r  <= 1'b0;
      csb_r       <= 1'b1;
      wsb_r       <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            if (num_rows != {(ADDR_W+1){1'b0}}) begin
              addr_r      <= base_addr;
              rows_left_r <= num_rows;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b1;
              state_r     <= FILL;
            end else begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        FILL: begin
          if (hs_s && last_beat_s) begin
            in_ready_r <= 1'b0;
            csb_r      <= 1'b0;
            wsb_r      <= 1'b0;
            state_r    <= WRITE;
          end
        end
        WRITE: begin
          csb_r       <= 1'b1;
          wsb_r       <= 1'b1;
          addr_r      <= addr_r + ADDR_W'(1'b1);
          rows_left_r <= rows_left_r - (ADDR_W+1)'(1'b1);
          if (rows_left_r == (ADDR_W+1)'(1'b1)) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= FILL;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          csb_r      <= 1'b1;
          wsb_r      <= 1'b1;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_W_LOADER_CHECKSUM_EN
  logic [WEIGHT_W-1:0] checksum_r;
  logic [WEIGHT_W-1:0] beat_sum_s;

  // Sum of the weights carried by the current beat, wrapping at the weight width.
  always_comb begin
    beat_sum_s = {WEIGHT_W{1'b0}};
    for (int i = 0; i < IN_W / WEIGHT_W; i++) begin
      beat_sum_s = beat_sum_s + in_data[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Running checksum, restarted whenever a command is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_r <= {WEIGHT_W{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      checksum_r <= {WEIGHT_W{1'b0}};
    end else if (hs_s) begin
      checksum_r <= checksum_r + beat_sum_s;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_sram_w_loader.sv
// Scoreboard bench for sram_w_loader: expected writes/done pulses are queued by stimulus, popped by a monitor.
module tb_sram_w_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   base_addr;
  logic [6:0]   num_rows;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic         sram_csb;
  logic         sram_wsb;
  logic [5:0]   sram_waddr;
  logic [511:0] sram_wdata;
  logic         busy;
  logic         done;
`ifdef SRAM_W_LOADER_CHECKSUM_EN
  logic [15:0]  checksum;
`endif

  always #5 clk = ~clk;

  sram_w_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .sram_csb   (sram_csb),
    .sram_wsb   (sram_wsb),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .busy       (busy),
    .done       (done)
`ifdef SRAM_W_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  typedef struct {
    logic [5:0]   addr;
    logic [511:0] data;
  } wr_t;

  wr_t          wq[$];
  logic [15:0]  dq[$];
  int           checks = 0;
  int           errors = 0;
  logic [511:0] mem_model[64];
  logic [511:0] mem_seen[64];
  bit           mem_valid[64];
  wr_t          mon_e;
`ifdef SRAM_W_LOADER_CHECKSUM_EN
  logic [15:0]  mon_sum;
`endif

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: every SRAM write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (sram_csb === 1'b0 || sram_wsb === 1'b0) begin
      chk("write_strobes", {sram_csb, sram_wsb}, 2'b00);
      chk("write_in_ready", in_ready, 1'b0);
      chk("write_busy", busy, 1'b1);
      if (wq.size() == 0) begin
        fail_now("unexpected_write", $sformatf("got write to %0d, expected none", sram_waddr));
      end else begin
        mon_e = wq.pop_front();
        chk("write_addr", sram_waddr, mon_e.addr);
        chk("write_data", sram_wdata, mon_e.data);
      end
      if (!$isunknown(sram_waddr)) mem_seen[sram_waddr] = sram_wdata;
    end
    if (done === 1'b1) begin
      chk("done_in_ready", in_ready, 1'b0);
      chk("done_busy", busy, 1'b0);
      chk("done_no_write", sram_csb, 1'b1);
      if (dq.size() == 0) begin
        fail_now("unexpected_done", "got done pulse, expected none");
      end else begin
`ifdef SRAM_W_LOADER_CHECKSUM_EN
        mon_sum = dq.pop_front();
        chk("done_checksum", checksum, mon_sum);
`else
        void'(dq.pop_front());
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [5:0] b, input logic [6:0] n);
    start     = 1'b1;
    base_addr = b;
    num_rows  = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input int gap_pct, output bit ok);
    bit rdy;
    ok = 1'b0;
    while (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && dq.size() != 0; i++) tick();
    if (dq.size() != 0) begin
      fail_now("done_timeout", "got no done pulse within 400 cycles, expected one");
      dq.delete();
      wq.delete();
    end else begin
      chk("writes_drained", wq.size(), 0);
    end
    tick();
    chk("idle_in_ready", in_ready, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  // Model: weight k of row r goes to bits [16k+15:16k] of the line written at (base+r) mod 64.
  task automatic load(input logic [5:0] b, input int n, input int gap_pct, input bit ramp, input bit poke);
    logic [511:0] lines[$];
    logic [511:0] line;
    logic [15:0]  w;
    logic [15:0]  sum;
    logic [5:0]   a;
    wr_t          e;
    bit           ok;
    sum = 16'd0;
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < 32; k++) begin
        w = ramp ? 16'(k) : 16'($urandom);
        line[16*k +: 16] = w;
        sum = sum + w;
      end
      a = 6'((int'(b) + r) % 64);
      e.addr = a;
      e.data = line;
      wq.push_back(e);
      mem_model[a] = line;
      mem_valid[a] = 1'b1;
      lines.push_back(line);
    end
    dq.push_back(sum);
    issue_start(b, 7'(n));
    chk("busy_after_start", busy, (n != 0) ? 1'b1 : 1'b0);
`ifdef SRAM_W_LOADER_CHECKSUM_EN
    chk("checksum_cleared_on_start", checksum, 16'd0);
`endif
    for (int r = 0; r < n; r++) begin
      for (int j = 0; j < 16; j++) begin
        if (poke && r == 0 && j == 5) begin
          start     = 1'b1;
          base_addr = b + 6'd9;
          num_rows  = 7'd5;
        end
        send_beat(lines[r][32*j +: 32], gap_pct, ok);
        start = 1'b0;
        if (!ok) begin
          fail_now("beat_timeout", $sformatf("row %0d beat %0d got no in_ready, expected accept", r, j));
          return;
        end
      end
    end
    wait_done();
    // An ignored start must not leave a command behind.
    repeat (20) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_csb"}, sram_csb, 1'b1);
    chk({tag, "_wsb"}, sram_wsb, 1'b1);
    chk({tag, "_waddr"}, sram_waddr, 6'd0);
    chk({tag, "_wdata"}, sram_wdata, 512'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
`ifdef SRAM_W_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 16'd0);
`endif
  endtask

  initial begin
    bit ok;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 6'd0;
    num_rows  = 7'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    for (int i = 0; i < 64; i++) mem_valid[i] = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single row of ramp weights at address 5.
    load(6'd5, 1, 0, 1'b1, 1'b0);
    // Address wrap 62, 63, 0, 1.
    load(6'd62, 4, 0, 1'b0, 1'b0);
    // Stalled input plus a start issued while busy.
    load(6'd20, 3, 50, 1'b0, 1'b1);
    // Zero-row command: done pulse, no write.
    load(6'd40, 0, 0, 1'b0, 1'b0);

    // Reset after seven beats of row 0 discards the partial line.
    issue_start(6'd10, 7'd2);
    for (int j = 0; j < 7; j++) begin
      send_beat($urandom, 0, ok);
      if (!ok) fail_now("reset_beat_timeout", "got no in_ready, expected accept");
    end
    rst = 1'b1;
    tick();
    check_reset_outputs("midload_reset");
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_idle_csb", sram_csb, 1'b1);

    // Ramp 0..31 sums to 496; the following load restarts the checksum.
    load(6'd0, 1, 0, 1'b1, 1'b0);
    load(6'd33, 2, 30, 1'b0, 1'b0);

    for (int a = 0; a < 64; a++) begin
      if (mem_valid[a]) chk($sformatf("sram_row_%0d", a), mem_seen[a], mem_model[a]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
